// File: rtl/range_decoder_core.sv
// range_decoder_core: binary range-decoding engine. Takes one bin request at a
// time (adaptive probability or equiprobable bypass), updates range R and code
// C, and pulls bitstream bytes to renormalise R back above 2^(RANGE_W-8).
module range_decoder_core #(
   parameter int RANGE_W = 24,
   parameter int PROB_W  = 12,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               init_pulse,
   input  logic               dec_valid,
   output logic               dec_ready,
   input  logic [PROB_W-1:0]  dec_prob,
   input  logic               dec_bypass,
   input  logic [7:0]         in_byte,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               out_valid,
   output logic               out_bit,
   output logic [RANGE_W-1:0] range_out,
   output logic [CNT_W-1:0]   bytes_consumed,
   output logic               error_flag,
   output logic               busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_READY,
      S_DECODE,
      S_RENORM,
      S_ERROR
   } state_t;

   localparam int NB   = RANGE_W / 8;
   localparam int IC_W = $clog2(NB) + 1;
   // Renormalisation threshold 2^(RANGE_W-8)
   localparam logic [RANGE_W-1:0] R_MIN = {7'h00, 1'b1, {(RANGE_W-8){1'b0}}};

   state_t             state;
   logic [RANGE_W-1:0] r_q;
   logic [RANGE_W-1:0] c_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [IC_W-1:0]    init_cnt;
   logic [PROB_W-1:0]  prob_q;
   logic               bypass_q;
   logic               bit_pend;

   logic               byte_take;
   logic [CNT_W-1:0]   cnt_inc;
   logic [RANGE_W-1:0] prod;
   logic [RANGE_W-1:0] split;
   logic               dec_ge;
   logic [RANGE_W-1:0] dec_r;
   logic [RANGE_W-1:0] dec_c;
   logic [RANGE_W-1:0] ren_r;
   logic [RANGE_W-1:0] ren_c;

   // Handshake/status flags decoded from the registered state; init_pulse
   // blocks byte intake in the cycle it aborts a stream.
   assign dec_ready      = (state == S_READY);
   assign busy           = (state == S_INIT) || (state == S_DECODE) || (state == S_RENORM);
   assign in_ready       = ((state == S_INIT) || (state == S_RENORM)) && !init_pulse;
   assign byte_take      = in_valid && in_ready;
   assign range_out      = r_q;
   assign bytes_consumed = cnt_q;

   // Saturating byte count
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   // (R >> PROB_W) has RANGE_W-PROB_W significant bits, so the product fits RANGE_W
   assign prod   = (r_q >> PROB_W) * RANGE_W'(prob_q);
   assign split  = bypass_q ? (r_q >> 1) : prod;
   assign dec_ge = (c_q >= split);
   assign dec_r  = dec_ge ? (r_q - split) : split;
   assign dec_c  = dec_ge ? (c_q - split) : c_q;

   // Byte shift used by both stream init and renormalisation
   assign ren_r  = {r_q[RANGE_W-9:0], 8'h00};
   assign ren_c  = {c_q[RANGE_W-9:0], in_byte};

   // Decoder FSM with registered datapath and result outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         r_q        <= '0;
         c_q        <= '0;
         cnt_q      <= '0;
         init_cnt   <= '0;
         prob_q     <= '0;
         bypass_q   <= 1'b0;
         bit_pend   <= 1'b0;
         out_valid  <= 1'b0;
         out_bit    <= 1'b0;
         error_flag <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (init_pulse) begin
            state      <= S_INIT;
            r_q        <= '1;
            c_q        <= '0;
            cnt_q      <= '0;
            init_cnt   <= '0;
            error_flag <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
               end
               S_INIT: begin
                  if (byte_take) begin
                     c_q      <= ren_c;
                     cnt_q    <= cnt_inc;
                     init_cnt <= init_cnt + 1'b1;
                     if (init_cnt == IC_W'(NB - 1)) begin
                        if (ren_c >= r_q) begin
                           state      <= S_ERROR;
                           error_flag <= 1'b1;
                        end else begin
                           state <= S_READY;
                        end
                     end
                  end
               end
               S_READY: begin
                  if (dec_valid) begin
                     prob_q   <= dec_prob;
                     bypass_q <= dec_bypass;
                     state    <= S_DECODE;
                  end
               end
               S_DECODE: begin
                  if (!bypass_q && (prob_q == '0)) begin
                     state      <= S_ERROR;
                     error_flag <= 1'b1;
                  end else begin
                     r_q      <= dec_r;
                     c_q      <= dec_c;
                     bit_pend <= dec_ge;
                     if (dec_c >= dec_r) begin
                        state      <= S_ERROR;
                        error_flag <= 1'b1;
                     end else if (dec_r >= R_MIN) begin
                        state     <= S_READY;
                        out_valid <= 1'b1;
                        out_bit   <= dec_ge;
                     end else begin
                        state <= S_RENORM;
                     end
                  end
               end
               S_RENORM: begin
                  if (byte_take) begin
                     r_q   <= ren_r;
                     c_q   <= ren_c;
                     cnt_q <= cnt_inc;
                     if (ren_c >= ren_r) begin
                        state      <= S_ERROR;
                        error_flag <= 1'b1;
                     end else if (ren_r >= R_MIN) begin
                        state     <= S_READY;
                        out_valid <= 1'b1;
                        out_bit   <= bit_pend;
                     end
                  end
               end
               S_ERROR: begin
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_range_decoder_core.sv
// tb_range_decoder_core: scoreboard bench for range_decoder_core. Expected bins,
// ranges and latencies come from a reference model of the decoding arithmetic.
module tb_range_decoder_core;

   localparam int RW = 24;
   localparam int PW = 12;
   localparam int CW = 4;
   localparam int unsigned CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          init_pulse;
   logic          dec_valid;
   logic          dec_ready;
   logic [PW-1:0] dec_prob;
   logic          dec_bypass;
   logic [7:0]    in_byte;
   logic          in_valid;
   logic          in_ready;
   logic          out_valid;
   logic          out_bit;
   logic [RW-1:0] range_out;
   logic [CW-1:0] bytes_consumed;
   logic          error_flag;
   logic          busy;

   range_decoder_core #(.RANGE_W(RW), .PROB_W(PW), .CNT_W(CW)) dut (
      .clk            (clk),
      .reset          (reset),
      .init_pulse     (init_pulse),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_prob       (dec_prob),
      .dec_bypass     (dec_bypass),
      .in_byte        (in_byte),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_valid      (out_valid),
      .out_bit        (out_bit),
      .range_out      (range_out),
      .bytes_consumed (bytes_consumed),
      .error_flag     (error_flag),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          b;
      logic [RW-1:0] r;
      int unsigned   acc;
      int unsigned   lat;
   } exp_t;

   exp_t        sbq[$];
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;

   // reference model state
   logic [31:0] m_r;
   logic [31:0] m_c;
   int unsigned m_cnt;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // monitor: every out_valid pulse must match the oldest pending expectation
   always @(negedge clk) begin : mon
      exp_t e;
      if (out_valid) begin
         if (sbq.size() == 0) begin
            chk("spurious_out_valid", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("out_bit", {31'd0, out_bit}, {31'd0, e.b});
            chk("range_out", {8'd0, range_out}, {8'd0, e.r});
            chk("latency", cyc - e.acc, e.lat);
         end
      end
   end

   function automatic int unsigned sat_inc(input int unsigned v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   // caller sits just after a posedge
   task automatic send_byte(input logic [7:0] b);
      bit ok = 0;
      in_byte  = b;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
      end
      if (!ok) chk("byte_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_dec_ready(output bit ok);
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = dec_ready;
      end
      if (!ok) chk("dec_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_in_ready(output bit ok);
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
      end
      if (!ok) chk("in_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic init_stream(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      logic [7:0] bs [3];
      bs = '{b0, b1, b2};
      @(posedge clk);
      #1 init_pulse = 1'b1;
      @(posedge clk);
      #1 init_pulse = 1'b0;
      m_r   = 32'hFF_FFFF;
      m_c   = 32'd0;
      m_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         send_byte(bs[i]);
         m_c   = ((m_c << 8) | {24'd0, bs[i]}) & 32'hFF_FFFF;
         m_cnt = sat_inc(m_cnt);
      end
      @(negedge clk);
      chk("init_error_flag", {31'd0, error_flag}, {31'd0, m_c >= m_r});
      chk("init_dec_ready", {31'd0, dec_ready}, {31'd0, m_c < m_r});
      chk("init_bytes", {28'd0, bytes_consumed}, m_cnt);
      chk("init_range", {8'd0, range_out}, m_r);
   endtask

   task automatic do_decode(input logic [PW-1:0] p, input logic byp, input logic [7:0] rb,
                            input int unsigned stall);
      exp_t        e;
      logic [31:0] sp;
      int unsigned nb = 0;
      bit          ok;
      wait_dec_ready(ok);
      if (!ok) return;
      sp = byp ? (m_r >> 1) : ((m_r >> 12) * {20'd0, p});
      if (m_c < sp) begin
         e.b = 1'b0;
         m_r = sp;
      end else begin
         e.b = 1'b1;
         m_c = m_c - sp;
         m_r = m_r - sp;
      end
      while (m_r < 32'h1_0000 && nb < 4) begin
         m_r   = m_r << 8;
         m_c   = ((m_c << 8) | {24'd0, rb}) & 32'hFF_FFFF;
         m_cnt = sat_inc(m_cnt);
         nb++;
      end
      e.r   = m_r[RW-1:0];
      e.acc = cyc;
      e.lat = 2 + nb + ((nb > 0) ? stall : 0);
      sbq.push_back(e);
      dec_prob   = p;
      dec_bypass = byp;
      dec_valid  = 1'b1;
      @(posedge clk);
      #1 dec_valid = 1'b0;
      for (int i = 0; i < nb; i++) begin
         if (i == 0 && stall > 0) begin
            wait_in_ready(ok);
            repeat (stall) @(posedge clk);
            #1;
         end
         send_byte(rb);
      end
      for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
      if (sbq.size() != 0) begin
         chk("out_valid_timeout", 32'd0, 32'd1);
         sbq.delete();
      end
      chk("dec_bytes", {28'd0, bytes_consumed}, m_cnt);
   endtask

   // start a prob=1 decode from a fresh 00,00,00 stream and stop in RENORM
   task automatic enter_renorm(output bit ok);
      init_stream(8'h00, 8'h00, 8'h00);
      wait_dec_ready(ok);
      if (!ok) return;
      dec_prob   = 12'h001;
      dec_bypass = 1'b0;
      dec_valid  = 1'b1;
      @(posedge clk);
      #1 dec_valid = 1'b0;
      wait_in_ready(ok);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      reset      = 1'b1;
      init_pulse = 1'b0;
      dec_valid  = 1'b0;
      dec_prob   = '0;
      dec_bypass = 1'b0;
      in_byte    = '0;
      in_valid   = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_flags", {26'd0, dec_ready, in_ready, out_valid, out_bit, error_flag, busy}, 32'd0);
      chk("reset_range", {8'd0, range_out}, 32'd0);
      chk("reset_bytes", {28'd0, bytes_consumed}, 32'd0);

      // prob 0x800, no renorm
      init_stream(8'h00, 8'h00, 8'h00);
      do_decode(12'h800, 1'b0, 8'h00, 0);
      chk("t1_bit", {31'd0, out_bit}, 32'd0);
      chk("t1_range", {8'd0, range_out}, 32'h7F_F800);
      chk("t1_bytes", {28'd0, bytes_consumed}, 32'd3);

      // bin 1, no byte consumed
      init_stream(8'hFF, 8'hFF, 8'hFE);
      do_decode(12'h001, 1'b0, 8'h00, 0);
      chk("t2_bit", {31'd0, out_bit}, 32'd1);
      chk("t2_range", {8'd0, range_out}, 32'hFF_F000);
      chk("t2_bytes", {28'd0, bytes_consumed}, 32'd3);

      // one-byte renorm, then the same with a 5-cycle intake stall
      init_stream(8'h00, 8'h00, 8'h00);
      do_decode(12'h001, 1'b0, 8'hAB, 0);
      chk("t3_range", {8'd0, range_out}, 32'h0F_FF00);
      chk("t3_bit", {31'd0, out_bit}, 32'd0);
      chk("t3_bytes", {28'd0, bytes_consumed}, 32'd4);
      init_stream(8'h00, 8'h00, 8'h00);
      do_decode(12'h001, 1'b0, 8'hAB, 5);

      // bypass
      init_stream(8'h80, 8'h00, 8'h00);
      do_decode(12'h000, 1'b1, 8'h00, 0);
      chk("t4_bit", {31'd0, out_bit}, 32'd1);
      chk("t4_range", {8'd0, range_out}, 32'h80_0000);

      // C == R at init
      init_stream(8'hFF, 8'hFF, 8'hFF);
      chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t5_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1 init_pulse = 1'b1;
      @(posedge clk);
      #1 init_pulse = 1'b0;
      @(negedge clk);
      chk("t5_clear_flag", {31'd0, error_flag}, 32'd0);
      chk("t5_clear_bytes", {28'd0, bytes_consumed}, 32'd0);

      // prob 0 request
      init_stream(8'h00, 8'h00, 8'h00);
      wait_dec_ready(ok);
      dec_prob   = 12'h000;
      dec_bypass = 1'b0;
      dec_valid  = 1'b1;
      @(posedge clk);
      #1 dec_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("p0_error_flag", {31'd0, error_flag}, 32'd1);
      chk("p0_dec_ready", {31'd0, dec_ready}, 32'd0);
      chk("p0_in_ready", {31'd0, in_ready}, 32'd0);

      // reset while in RENORM
      enter_renorm(ok);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("rr_flags", {26'd0, dec_ready, in_ready, out_valid, out_bit, error_flag, busy}, 32'd0);
      chk("rr_range", {8'd0, range_out}, 32'd0);
      chk("rr_bytes", {28'd0, bytes_consumed}, 32'd0);

      // init_pulse while in RENORM with a byte offered the same cycle
      enter_renorm(ok);
      in_byte    = 8'hAB;
      in_valid   = 1'b1;
      init_pulse = 1'b1;
      #1 chk("ab_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1 init_pulse = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("ab_bytes", {28'd0, bytes_consumed}, 32'd0);
      chk("ab_busy_inrdy", {30'd0, busy, in_ready}, 32'd3);
      repeat (4) @(negedge clk);
      init_stream(8'h00, 8'h00, 8'h00);
      do_decode(12'h800, 1'b0, 8'h00, 0);

      // byte counter saturation
      init_stream(8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 10; i++) do_decode(12'h001, 1'b0, 8'h00, 0);
      chk("sat_bytes", {28'd0, bytes_consumed}, CMAX);

      // random stream
      init_stream(8'($urandom_range(0, 254)), 8'($urandom), 8'($urandom));
      for (int i = 0; i < 24; i++)
         do_decode(PW'($urandom_range(1, 4095)), 1'($urandom_range(0, 1)),
                   8'($urandom), $urandom_range(0, 2));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/range_decoder_core.md
Name: range_decoder_core

Overview:
- Parametrised successor to the entropy-decoder range calculation path: a complete binary range-decoding engine with an adaptive-probability input, bypass (equiprobable) mode, byte-serial bitstream intake and multi-step renormalisation.
- Sits between the bitstream byte FIFO and the context/probability modeller in the LiDAR entropy decoder.
- Decodes one bin per request, using valid/ready handshakes on all sides.

Parameters:
- RANGE_W, 24: range and code register width; must be a multiple of 8 and at least 16.
- PROB_W, 12: probability width; must satisfy PROB_W <= RANGE_W-8.
- CNT_W, 16: width of the consumed-byte counter.

Ports:
- clk in 1: system clock.
- reset in 1: synchronous, active-high reset.
- init_pulse in 1: starts a new stream; accepted in any state and has priority over everything except reset.
- dec_valid in 1: decode request.
- dec_ready out 1: high only in READY.
- dec_prob in PROB_W: probability of bin 0, scaled by 2^PROB_W; ignored when dec_bypass=1.
- dec_bypass in 1: equiprobable decode.
- in_byte in 8: bitstream byte.
- in_valid in 1: in_byte is valid.
- in_ready out 1: high in INIT and RENORM.
- out_valid out 1: one-cycle pulse when a decoded bin is available.
- out_bit out 1: decoded bin.
- range_out out RANGE_W: current range R.
- bytes_consumed out CNT_W: bytes accepted since the last init.
- error_flag out 1: sticky error indication.
- busy out 1: high in INIT, DECODE and RENORM.

Behaviour:
- Reset values: state=IDLE, R=0, C=0, every output 0, byte counter 0.
- IDLE:
  - init_pulse -> INIT, with R=2^RANGE_W-1, C=0, count=0, error_flag=0.
  - dec_ready=0.
- INIT:
  - in_ready=1.
  - Each in_valid&&in_ready cycle: C={C[RANGE_W-9:0],in_byte}, count+1.
  - After RANGE_W/8 bytes: if C>=R -> ERROR, else -> READY.
- READY:
  - dec_ready=1; the request is captured on dec_valid&&dec_ready.
  - Next state is DECODE, taking prob and bypass as registered.
- DECODE (1 cycle):
  - split = bypass ? R>>1 : (R>>PROB_W)*prob, truncated to RANGE_W bits.
  - If the non-bypass prob==0 -> ERROR.
  - If C<split: bit=0, R=split.
  - Otherwise: bit=1, C=C-split, R=R-split.
  - If the new R >= 2^(RANGE_W-8) -> READY with out_valid=1; otherwise -> RENORM.
- RENORM:
  - in_ready=1.
  - Each accepted byte: R=R<<8, C=(C<<8)|in_byte, count+1.
  - When R>=2^(RANGE_W-8) after a shift -> READY with out_valid=1.
  - With in_valid=0 the block stalls, holding state with no timeout.
- Latency:
  - No renormalisation: request accept to out_valid is 2 cycles.
  - Otherwise 2 cycles plus one cycle per byte, plus any stall cycles.
- out_bit and range_out hold their values until the next decode.
- ERROR:
  - error_flag=1 (sticky).
  - dec_ready=0 and in_ready=0.
  - Exits only on init_pulse (-> INIT, flag cleared) or reset.
- Invariant: C<R after every DECODE/RENORM. A violation moves to ERROR; it cannot arise from a valid stream.
- bytes_consumed saturates at 2^CNT_W-1 and does not wrap.
- init_pulse mid-INIT or mid-RENORM:
  - Abort and restart INIT.
  - A byte presented in that same cycle is not consumed (in_ready is forced 0 that cycle).
  - A pending bin is discarded and out_valid is not pulsed.
- All arithmetic is unsigned. The multiply is (RANGE_W-PROB_W) x PROB_W bits and cannot exceed RANGE_W.

Test Plan:
- Init with bytes 00,00,00, then decode prob=0x800 -> after 3 bytes dec_ready=1; out_bit=0, range_out=0x7FF800, out_valid 2 cycles after accept, bytes_consumed=3.
- Init with FF,FF,FE, then decode prob=0x001 -> out_bit=1, range_out=0xFFF000, no byte consumed.
- Init with 00,00,00, decode prob=0x001 with in_byte=0xAB -> RENORM consumes 1 byte, range_out=0x0FFF00, out_bit=0, bytes_consumed=4; holding in_valid=0 for 5 cycles delays out_valid by exactly 5.
- Bypass decode after init with 80,00,00 -> split=0x7FFFFF, out_bit=1, range_out=0x800000.
- Init with FF,FF,FF -> C==R, ERROR, error_flag=1, dec_ready=0; a dec_prob=0 request after a valid init also gives ERROR; init_pulse clears error_flag and count.
- Reset and init_pulse asserted mid-RENORM -> reset gives all outputs 0 next cycle; init_pulse gives INIT, no out_valid pulse, bytes_consumed=0.
